mux_sel_serializer: RTL and testbench

//  Parallel-in/serial-out sequencer that sits directly upstream of mux_4x1.
//  - Accepts one LANES-bit word over a valid/ready handshake.
//  - Holds the word on mux_i and steps mux_s through every lane, one lane per clock.
//  - The mux output y is therefore the serial bit stream.
//  - Emits framing strobes aligned to y; back-to-back words stream with no idle gap.

---
 rtl/mux_sel_serializer_if.sv | 27 ++
 rtl/mux_sel_serializer.sv | 110 +++++++++++
 tb/tb_mux_sel_serializer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mux_sel_serializer_if.sv
// Handshake and mux-drive bundle between the upstream word source and the
// serializer that sequences a downstream LANES-to-1 mux.
interface mux_sel_serializer_if #(
    parameter int LANES = 4
);
    localparam int SEL_W = $clog2(LANES);

    logic [LANES-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] mux_i;
    logic [SEL_W-1:0] mux_s;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, mux_i, mux_s, ser_valid, ser_first, ser_last, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mux_i, mux_s, ser_valid, ser_first, ser_last, busy
    );
endinterface

// File: rtl/mux_sel_serializer.sv
// Parallel-in/serial-out sequencer: holds a word on mux_i and walks mux_s
// over every lane, one lane per clock, with framing strobes aligned to y.
module mux_sel_serializer #(
    parameter int LANES     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_sel_serializer_if.slave  bus
);
    localparam int SEL_W = $clog2(LANES);
    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);
    localparam logic [SEL_W-1:0] SEL_START = MSB_FIRST ? LAST_LANE : {SEL_W{1'b0}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r, next_state_s;
    logic [SEL_W-1:0] cnt_r, next_cnt_s;
    logic [LANES-1:0] mux_i_r, next_mux_i_s;
    logic [SEL_W-1:0] mux_s_r, next_mux_s_s;
    logic             ser_valid_r, ser_first_r, ser_last_r, busy_r;
    logic             in_ready_s, accept_s;

    // Ready is open in IDLE and on the last lane so words stream without a gap.
    always_comb begin
        in_ready_s = 1'b0;
        if (state_r == IDLE) begin
            in_ready_s = 1'b1;
        end else if (cnt_r == LAST_LANE) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = bus.in_valid & in_ready_s;
    end

    // Next-state, lane counter, held word and select computation.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        next_mux_i_s = mux_i_r;
        next_mux_s_s = mux_s_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = SHIFT;
                    next_cnt_s   = {SEL_W{1'b0}};
                    next_mux_i_s = bus.in_data;
                    next_mux_s_s = SEL_START;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r != LAST_LANE) begin
                    next_cnt_s   = cnt_r + SEL_W'(1);
                    next_mux_s_s = MSB_FIRST ? (LAST_LANE - next_cnt_s) : next_cnt_s;
                end else if (accept_s) begin
                    next_cnt_s   = {SEL_W{1'b0}};
                    next_mux_i_s = bus.in_data;
                    next_mux_s_s = SEL_START;
                end else begin
                    // Last word stays on mux_i; only the select parks at zero.
                    next_state_s = IDLE;
                    next_cnt_s   = {SEL_W{1'b0}};
                    next_mux_s_s = {SEL_W{1'b0}};
                end
            end
            default: begin
                next_state_s = IDLE;
                next_cnt_s   = {SEL_W{1'b0}};
                next_mux_s_s = {SEL_W{1'b0}};
            end
        endcase
    end

    // State, datapath and registered framing strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {SEL_W{1'b0}};
            mux_i_r     <= {LANES{1'b0}};
            mux_s_r     <= {SEL_W{1'b0}};
            ser_valid_r <= 1'b0;
            ser_first_r <= 1'b0;
            ser_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cnt_r       <= next_cnt_s;
            mux_i_r     <= next_mux_i_s;
            mux_s_r     <= next_mux_s_s;
            ser_valid_r <= (next_state_s == SHIFT);
            ser_first_r <= (next_state_s == SHIFT) && (next_cnt_s == {SEL_W{1'b0}});
            ser_last_r  <= (next_state_s == SHIFT) && (next_cnt_s == LAST_LANE);
            busy_r      <= (next_state_s == SHIFT);
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.mux_i     = mux_i_r;
    assign bus.mux_s     = mux_s_r;
    assign bus.ser_valid = ser_valid_r;
    assign bus.ser_first = ser_first_r;
    assign bus.ser_last  = ser_last_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_mux_sel_serializer.sv
// Directed bench for mux_sel_serializer: LSB-first, MSB-first and 8-lane builds.
module tb_mux_sel_serializer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mux_sel_serializer_if #(.LANES(4)) if0 ();
    mux_sel_serializer_if #(.LANES(4)) if1 ();
    mux_sel_serializer_if #(.LANES(8)) if2 ();

    mux_sel_serializer #(.LANES(4), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mux_sel_serializer #(.LANES(4), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mux_sel_serializer #(.LANES(8), .MSB_FIRST(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    // Downstream mux outputs as the mux would produce them.
    logic y0, y1, y2;
    assign y0 = if0.mux_i[if0.mux_s];
    assign y1 = if1.mux_i[if1.mux_s];
    assign y2 = if2.mux_i[if2.mux_s];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp3;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        if0.in_data = 4'h0; if0.in_valid = 1'b0;
        if1.in_data = 4'h0; if1.in_valid = 1'b0;
        if2.in_data = 8'h00; if2.in_valid = 1'b0;
        #12;
        check("rst_ready", 32'(if0.in_ready), 32'd1);
        check("rst_valid", 32'(if0.ser_valid), 32'd0);
        check("rst_mux_s", 32'(if0.mux_s), 32'd0);
        check("rst_mux_i", 32'(if0.mux_i), 32'd0);
        #8 rst_n = 1'b1;   // released at t=20, a falling edge
        tick();

        // Single word 4'b1010, LSB first.
        if0.in_data = 4'b1010; if0.in_valid = 1'b1;
        tick();
        if0.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("w1_valid", 32'(if0.ser_valid), 32'd1);
            check("w1_busy",  32'(if0.busy), 32'd1);
            check("w1_mux_s", 32'(if0.mux_s), 32'(k));
            check("w1_y",     32'(y0), 32'((k % 2) == 1));
            check("w1_first", 32'(if0.ser_first), 32'(k == 0));
            check("w1_last",  32'(if0.ser_last), 32'(k == 3));
            check("w1_ready", 32'(if0.in_ready), 32'(k == 3));
            tick();
        end
        check("w1_idle_valid", 32'(if0.ser_valid), 32'd0);
        check("w1_idle_ready", 32'(if0.in_ready), 32'd1);
        check("w1_idle_mux_s", 32'(if0.mux_s), 32'd0);
        check("w1_idle_mux_i", 32'(if0.mux_i), 32'hA);

        // Back-to-back 4'hA then 4'h5 with in_valid held high.
        exp3 = 8'h5A;
        if0.in_data = 4'hA; if0.in_valid = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            check("b2b_valid", 32'(if0.ser_valid), 32'd1);
            check("b2b_y",     32'(y0), 32'(exp3[k]));
            check("b2b_first", 32'(if0.ser_first), 32'((k % 4) == 0));
            check("b2b_last",  32'(if0.ser_last), 32'((k % 4) == 3));
            check("b2b_ready", 32'(if0.in_ready), 32'((k % 4) == 3));
            if (k == 0) if0.in_data = 4'h5;
            if (k == 7) if0.in_valid = 1'b0;
            tick();
        end
        check("b2b_end_valid", 32'(if0.ser_valid), 32'd0);
        check("b2b_end_ready", 32'(if0.in_ready), 32'd1);

        // in_data churning while not ready must not reach mux_i.
        if0.in_data = 4'h3; if0.in_valid = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("hold_mux_i", 32'(if0.mux_i), 32'h3);
            if0.in_data = 4'(k + 8);
            tick();
        end
        check("hold_mux_i_last", 32'(if0.mux_i), 32'h3);
        check("hold_last",       32'(if0.ser_last), 32'd1);
        if0.in_data = 4'h6;
        tick();
        if0.in_valid = 1'b0;
        check("reload_mux_i",  32'(if0.mux_i), 32'h6);
        check("reload_first",  32'(if0.ser_first), 32'd1);
        check("reload_mux_s",  32'(if0.mux_s), 32'd0);
        tick(); tick(); tick();
        check("reload_last",   32'(if0.ser_last), 32'd1);
        tick();
        check("reload_idle",   32'(if0.busy), 32'd0);

        // Asynchronous reset during bit 2 of 4'hF, then word 4'h1.
        if0.in_data = 4'hF; if0.in_valid = 1'b1;
        tick();
        if0.in_valid = 1'b0;
        tick(); tick();
        check("abort_pre_mux_s", 32'(if0.mux_s), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(if0.ser_valid), 32'd0);
        check("abort_busy",  32'(if0.busy), 32'd0);
        check("abort_mux_s", 32'(if0.mux_s), 32'd0);
        check("abort_ready", 32'(if0.in_ready), 32'd1);
        check("abort_mux_i", 32'(if0.mux_i), 32'd0);
        #1 rst_n = 1'b1;
        if0.in_data = 4'h1; if0.in_valid = 1'b1;
        tick();
        if0.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("post_mux_s", 32'(if0.mux_s), 32'(k));
            check("post_y",     32'(y0), 32'(k == 0));
            check("post_first", 32'(if0.ser_first), 32'(k == 0));
            tick();
        end
        check("post_idle", 32'(if0.ser_valid), 32'd0);

        // MSB-first build, word 4'b1000.
        if1.in_data = 4'b1000; if1.in_valid = 1'b1;
        tick();
        if1.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("msb_mux_s", 32'(if1.mux_s), 32'(3 - k));
            check("msb_y",     32'(y1), 32'(k == 0));
            check("msb_last",  32'(if1.ser_last), 32'(k == 3));
            tick();
        end
        check("msb_idle_mux_s", 32'(if1.mux_s), 32'd0);
        check("msb_idle_valid", 32'(if1.ser_valid), 32'd0);

        // 8-lane build, word 8'hA5 (bits 1,0,1,0,0,1,0,1 from lane 0).
        exp3 = 8'hA5;
        if2.in_data = 8'hA5; if2.in_valid = 1'b1;
        tick();
        if2.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("l8_valid", 32'(if2.ser_valid), 32'd1);
            check("l8_mux_s", 32'(if2.mux_s), 32'(k));
            check("l8_y",     32'(y2), 32'(exp3[k]));
            check("l8_last",  32'(if2.ser_last), 32'(k == 7));
            check("l8_ready", 32'(if2.in_ready), 32'(k == 7));
            tick();
        end
        check("l8_idle", 32'(if2.ser_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
